// File: rtl/aes_arbiter.sv
// -----------------------------------------------------------------------------
// aes_arbiter
//   Lets two requesters share a single AES core. Each requester hands over a
//   128-bit block and key over a valid/ready handshake. Grants go round-robin.
//   The arbiter sequences the core's reset/start, aborts a job whose core
//   never signals done, and returns the result on one response channel tagged
//   with the requester id.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready/data/key   requester N block handshake (N = 0, 1)
//   rsp_valid/ready             response handshake
//   rsp_data                    ciphertext (0 when the core timed out)
//   rsp_id                      requester that owns the response
//   rsp_err                     1 = core timed out
//   aes_rst                     core reset; 1 holds the core, 0 runs it
//   aes_din, aes_keyin          block and key presented to the core
//   aes_dout, aes_done          result and completion from the core
//   busy                        1 in any state but IDLE
// -----------------------------------------------------------------------------
module aes_arbiter #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_id,
  output logic         rsp_err,
  output logic         aes_rst,
  output logic [127:0] aes_din,
  output logic [127:0] aes_keyin,
  input  logic [127:0] aes_dout,
  input  logic         aes_done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_e;

  state_e             state_q, state_d;
  logic [127:0]       din_q, din_d;
  logic [127:0]       key_q, key_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [127:0]       rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic grant;     // requester that would win this cycle
  logic any_req;
  logic accept;
  logic timeout;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
  end

  assign accept  = (state_q == IDLE) && any_req;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      din_q        <= '0;
      key_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;   // so requester 0 wins the first tie
      cnt_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      key_q        <= key_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a hold default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    key_d        = key_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          din_d        = grant ? req1_data : req0_data;
          key_d        = grant ? req1_key  : req0_key;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Done takes priority over a timeout landing on the same cycle.
        if (aes_done) begin
          rsp_data_d  = aes_dout;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (timeout) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    req0_ready = accept && !grant;
    req1_ready = accept &&  grant;
    aes_rst    = (state_q != RUN);
    busy       = (state_q != IDLE);
  end

  assign aes_din   = din_q;
  assign aes_keyin = key_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_aes_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_arbiter
//   Drives randomized jobs into aes_arbiter through a stub AES core whose
//   latency (or hang) is chosen per job, and compares against a job-level
//   model: round-robin grant history, expected latency and response contents.
// -----------------------------------------------------------------------------
module tb_aes_arbiter;

  localparam int TIMEOUT = 64;

  localparam logic [127:0] FIPS_KEY  = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] FIPS_DATA = 128'h340737e0a29831318d305a88a8f64332;
  localparam logic [127:0] FIPS_CT   = 128'h320b6a19978511dcfb09dc021d842539;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [127:0] req0_data, req0_key, req1_data, req1_key;
  logic         rsp_valid, rsp_ready;
  logic [127:0] rsp_data;
  logic         rsp_id, rsp_err;
  logic         aes_rst;
  logic [127:0] aes_din, aes_keyin, aes_dout;
  logic         aes_done;
  logic         busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: who was served last (reset value makes req0 win the first tie).
  bit last_grant = 1'b1;

  // Stub core controls.
  int stub_lat  = 0;
  bit stub_hang = 1'b0;
  bit spurious  = 1'b0;
  int stub_cnt;

  aes_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_key(req0_key),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_key(req1_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .aes_rst(aes_rst), .aes_din(aes_din), .aes_keyin(aes_keyin),
    .aes_dout(aes_dout), .aes_done(aes_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in cipher: the FIPS-197 vector maps to its known ciphertext,
  // anything else to a cheap but key- and data-dependent value.
  function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == FIPS_DATA && k == FIPS_KEY) return FIPS_CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Stub core: counts cycles out of reset, raises done after stub_lat cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       stub_cnt <= 0;
    else if (aes_rst) stub_cnt <= 0;
    else              stub_cnt <= stub_cnt + 1;
  end
  assign aes_done = spurious | (!aes_rst && !stub_hang && stub_cnt >= stub_lat);
  assign aes_dout = core_fn(aes_din, aes_keyin);

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values();
    check("rst_busy",      128'(busy),      128'(0));
    check("rst_aes_rst",   128'(aes_rst),   128'(1));
    check("rst_aes_din",   aes_din,         128'(0));
    check("rst_aes_keyin", aes_keyin,       128'(0));
    check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    check("rst_rsp_data",  rsp_data,        128'(0));
    check("rst_rsp_id",    128'(rsp_id),    128'(0));
    check("rst_rsp_err",   128'(rsp_err),   128'(0));
  endtask

  // One complete job. Entered and left just after a falling edge with the
  // arbiter in IDLE. hold = cycles rsp_ready is withheld (with req0 pushing).
  task automatic job(input bit v0, input bit v1,
                     input logic [127:0] d0, input logic [127:0] k0,
                     input logic [127:0] d1, input logic [127:0] k1,
                     input int lat, input bit hang, input int hold);
    bit           g, exp_err;
    logic [127:0] ed, ek, exp_data;
    int           n, exp_n;
    stub_lat   = lat;
    stub_hang  = hang;
    req0_valid = v0; req0_data = d0; req0_key = k0;
    req1_valid = v1; req1_data = d1; req1_key = k1;
    #1;
    g = (v0 && v1) ? ~last_grant : v1;
    check("req0_ready", 128'(req0_ready), 128'(!g));
    check("req1_ready", 128'(req1_ready), 128'(g));
    check("busy_idle",  128'(busy),       128'(0));
    last_grant = g;
    ed       = g ? d1 : d0;
    ek       = g ? k1 : k0;
    exp_err  = hang || (lat >= TIMEOUT);
    exp_data = exp_err ? 128'(0) : core_fn(ed, ek);
    exp_n    = exp_err ? TIMEOUT + 1 : lat + 2;

    // LOAD cycle: requester inputs are free to change now.
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = rnd128(); req0_key = rnd128();
    req1_data = rnd128(); req1_key = rnd128();
    #1;
    check("aes_din",     aes_din,   ed);
    check("aes_keyin",   aes_keyin, ek);
    check("load_aes_rst", 128'(aes_rst), 128'(1));
    check("load_busy",    128'(busy),    128'(1));

    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1 && !rsp_valid) check("run_aes_rst", 128'(aes_rst), 128'(0));
    end
    check("latency",   128'(n),       128'(exp_n));
    check("rsp_data",  rsp_data,      exp_data);
    check("rsp_id",    128'(rsp_id),  128'(g));
    check("rsp_err",   128'(rsp_err), 128'(exp_err));
    check("resp_aes_rst", 128'(aes_rst), 128'(1));

    // Back-pressure: response must hold, no new grant, done is ignored.
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = $urandom_range(0, 1);
      spurious   = 1'b1;
      #1;
      check("hold_valid", 128'(rsp_valid), 128'(1));
      check("hold_data",  rsp_data,        exp_data);
      check("hold_id",    128'(rsp_id),    128'(g));
      check("hold_err",   128'(rsp_err),   128'(exp_err));
      check("hold_ready", 128'(req0_ready | req1_ready), 128'(0));
      check("hold_busy",  128'(busy),      128'(1));
    end
    spurious   = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("post_rsp_valid", 128'(rsp_valid), 128'(0));
    check("post_busy",      128'(busy),      128'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_data = '0; req0_key = '0; req1_data = '0; req1_key = '0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 vector on requester 0.
    job(1, 0, FIPS_DATA, FIPS_KEY, rnd128(), rnd128(), 10, 0, 0);

    // Ties alternate; history currently says req0 was last, so req1 first.
    for (int i = 0; i < 3; i++)
      job(1, 1, rnd128(), rnd128(), rnd128(), rnd128(), $urandom_range(0, 8), 0, 0);

    // Only requester 1, back to back.
    for (int i = 0; i < 3; i++)
      job(0, 1, rnd128(), rnd128(), rnd128(), rnd128(), $urandom_range(0, 5), 0, 0);

    // Hung core, done coinciding with timeout, done one cycle too late.
    job(1, 0, rnd128(), rnd128(), rnd128(), rnd128(), 0, 1, 0);
    job(0, 1, rnd128(), rnd128(), rnd128(), rnd128(), TIMEOUT - 1, 0, 0);
    job(1, 0, rnd128(), rnd128(), rnd128(), rnd128(), TIMEOUT, 0, 0);

    // Response withheld for 10 cycles while req0 keeps asking.
    job(1, 0, rnd128(), rnd128(), rnd128(), rnd128(), 3, 0, 10);

    // Randomized mix.
    for (int i = 0; i < 20; i++) begin
      int sel;
      sel = $urandom_range(1, 3);
      job(sel[0], sel[1], rnd128(), rnd128(), rnd128(), rnd128(),
          $urandom_range(0, 70), ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    // Reset while the core is running: job vanishes, history restarts.
    stub_lat = 40; stub_hang = 1'b0;
    req0_valid = 1'b1; req0_data = rnd128(); req0_key = rnd128();
    @(negedge clk);
    req0_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1'b1;
    @(negedge clk);
    #1;
    check("reset_no_rsp", 128'(rsp_valid), 128'(0));
    job(1, 1, rnd128(), rnd128(), rnd128(), rnd128(), 7, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
